// File: rtl/uart_txrx_if.sv
// ============================================================================
// uart_txrx_if : parallel-side and serial-pin signals of the uart_txrx block
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_txrx_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;

  modport slave (
    input  i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    output o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
  );

  modport master (
    output i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    input  o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
  );
endinterface

`default_nettype wire

// File: rtl/uart_txrx.sv
// ============================================================================
// uart_txrx : full-duplex 8N1 UART, TX and RX share one compile-time baud divider
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_txrx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  wire logic  i_Clock,
  input  wire logic  i_Reset,
  uart_txrx_if.slave io_uart
);

  localparam int             c_CNT_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MID = c_CNT_W'((CLKS_PER_BIT - 1) / 2);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_START   = 3'd1;
  localparam logic [2:0] c_DATA    = 3'd2;
  localparam logic [2:0] c_STOP    = 3'd3;
  localparam logic [2:0] c_CLEANUP = 3'd4;

  // ---------------------------------------------------------------- TX
  logic [2:0]         r_tx_state, w_tx_state_nxt;
  logic [c_CNT_W-1:0] r_tx_cnt,   w_tx_cnt_nxt;
  logic [2:0]         r_tx_idx,   w_tx_idx_nxt;
  logic [7:0]         r_tx_data,  w_tx_data_nxt;
  logic               w_tx_serial, w_tx_active, w_tx_done;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_tx_state <= c_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_data  <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_data_nxt  = r_tx_data;
    case (r_tx_state)
      c_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_idx_nxt = '0;
        if (io_uart.i_Tx_DV) begin
          w_tx_data_nxt  = io_uart.i_Tx_Byte;
          w_tx_state_nxt = c_START;
        end
      end
      c_START: begin
        if (r_tx_cnt < c_CNT_MAX) begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end else begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = c_DATA;
        end
      end
      c_DATA: begin
        if (r_tx_cnt < c_CNT_MAX) begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end else begin
          w_tx_cnt_nxt = '0;
          if (r_tx_idx == 3'd7) begin
            w_tx_idx_nxt   = '0;
            w_tx_state_nxt = c_STOP;
          end else begin
            w_tx_idx_nxt = r_tx_idx + 3'd1;
          end
        end
      end
      c_STOP: begin
        if (r_tx_cnt < c_CNT_MAX) begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end else begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = c_CLEANUP;
        end
      end
      c_CLEANUP: w_tx_state_nxt = c_IDLE;
      default:   w_tx_state_nxt = c_IDLE;
    endcase
  end

  // Outputs decode straight from state so the line is idle-high the cycle after reset
  always_comb begin
    w_tx_serial = 1'b1;
    w_tx_active = 1'b0;
    w_tx_done   = 1'b0;
    case (r_tx_state)
      c_START: begin
        w_tx_serial = 1'b0;
        w_tx_active = 1'b1;
      end
      c_DATA: begin
        w_tx_serial = r_tx_data[r_tx_idx];
        w_tx_active = 1'b1;
      end
      c_STOP:    w_tx_active = 1'b1;
      c_CLEANUP: w_tx_done   = 1'b1;
      default: ;
    endcase
  end

  assign io_uart.o_Tx_Serial = w_tx_serial;
  assign io_uart.o_Tx_Active = w_tx_active;
  assign io_uart.o_Tx_Done   = w_tx_done;

  // ---------------------------------------------------------------- RX
  logic               r_rx_meta, r_rx_sync;
  logic [2:0]         r_rx_state, w_rx_state_nxt;
  logic [c_CNT_W-1:0] r_rx_cnt,   w_rx_cnt_nxt;
  logic [2:0]         r_rx_idx,   w_rx_idx_nxt;
  logic [7:0]         r_rx_shift, w_rx_shift_nxt;
  logic [7:0]         r_rx_byte,  w_rx_byte_nxt;
  logic               r_rx_good,  w_rx_good_nxt;
  logic               w_rx_dv;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= c_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_good  <= 1'b0;
    end else begin
      r_rx_meta  <= io_uart.i_Rx_Serial;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_byte  <= w_rx_byte_nxt;
      r_rx_good  <= w_rx_good_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_byte_nxt  = r_rx_byte;
    w_rx_good_nxt  = r_rx_good;
    case (r_rx_state)
      c_IDLE: begin
        // Preload 1 so the mid-bit check lands (CLKS_PER_BIT-1)/2 cycles after detection
        w_rx_cnt_nxt  = c_CNT_W'(1);
        w_rx_idx_nxt  = '0;
        w_rx_good_nxt = 1'b0;
        if (!r_rx_sync) w_rx_state_nxt = c_START;
      end
      c_START: begin
        if (r_rx_cnt == c_CNT_MID) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = r_rx_sync ? c_IDLE : c_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      c_DATA: begin
        if (r_rx_cnt < c_CNT_MAX) begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end else begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_idx == 3'd7) begin
            w_rx_idx_nxt   = '0;
            w_rx_state_nxt = c_STOP;
          end else begin
            w_rx_idx_nxt = r_rx_idx + 3'd1;
          end
        end
      end
      c_STOP: begin
        if (r_rx_cnt < c_CNT_MAX) begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end else begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = c_CLEANUP;
          if (r_rx_sync) begin
            w_rx_byte_nxt = r_rx_shift;
            w_rx_good_nxt = 1'b1;
          end
        end
      end
      c_CLEANUP: begin
        w_rx_good_nxt  = 1'b0;
        w_rx_state_nxt = c_IDLE;
      end
      default: w_rx_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_rx_dv = (r_rx_state == c_CLEANUP) && r_rx_good;
  end

  assign io_uart.o_Rx_DV   = w_rx_dv;
  assign io_uart.o_Rx_Byte = r_rx_byte;

endmodule

`default_nettype wire

// File: tb/tb_uart_txrx.sv
// ============================================================================
// tb_uart_txrx : directed scoreboard bench for uart_txrx at 87 clocks per bit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_txrx;

  localparam int c_CPB = 87;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_en = 1'b0;
  logic rx_line = 1'b1;

  int n_cmp = 0;
  int n_mis = 0;
  int rx_dv_cnt = 0;
  int tx_done_cnt = 0;
  logic [7:0] sb[$];
  logic [7:0] sb_exp;

  uart_txrx_if uif ();

  assign uif.i_Rx_Serial = loop_en ? uif.o_Tx_Serial : rx_line;

  uart_txrx #(.CLKS_PER_BIT(c_CPB)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .io_uart (uif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every received byte
  always @(negedge clk) begin
    if (uif.o_Tx_Done === 1'b1) tx_done_cnt++;
    if (uif.o_Rx_DV === 1'b1) begin
      rx_dv_cnt++;
      chk("rx_dv_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        sb_exp = sb.pop_front();
        chk("rx_byte_scoreboard", {24'd0, uif.o_Rx_Byte}, {24'd0, sb_exp});
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input int start_len, input int bit_len,
                         input logic stop_val);
    rx_line = 1'b0;
    repeat (start_len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (bit_len) @(negedge clk);
    end
    rx_line = stop_val;
    repeat (bit_len) @(negedge clk);
    rx_line = 1'b1;
  endtask

  task automatic wait_tx_done(input string tag);
    int n;
    n = 0;
    while (uif.o_Tx_Done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, uif.o_Tx_Done}, 32'd1);
  endtask

  task automatic tx_start(input logic [7:0] b);
    @(negedge clk);
    uif.i_Tx_DV   = 1'b1;
    uif.i_Tx_Byte = b;
    @(negedge clk);
    uif.i_Tx_DV   = 1'b0;
  endtask

  logic [9:0] frame;
  int good;
  int dv_base;
  int done_base;

  initial begin
    uif.i_Tx_DV   = 1'b0;
    uif.i_Tx_Byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", {31'd0, uif.o_Tx_Serial}, 32'd1);
    chk("rst_tx_active", {31'd0, uif.o_Tx_Active}, 32'd0);
    chk("rst_tx_done",   {31'd0, uif.o_Tx_Done},   32'd0);
    chk("rst_rx_dv",     {31'd0, uif.o_Rx_DV},     32'd0);
    chk("rst_rx_byte",   {24'd0, uif.o_Rx_Byte},   32'h00);
    rst = 1'b0;

    // TX 0xAB: each frame bit held 87 cycles with Active high, then one Done cycle
    frame = {1'b1, 8'hAB, 1'b0};
    done_base = tx_done_cnt;
    tx_start(8'hAB);
    for (int b = 0; b < 10; b++) begin
      good = 0;
      for (int c = 0; c < c_CPB; c++) begin
        if (uif.o_Tx_Serial === frame[b] && uif.o_Tx_Active === 1'b1) good++;
        @(negedge clk);
      end
      chk($sformatf("tx_AB_bit%0d", b), good, c_CPB);
    end
    chk("tx_AB_done_871",   {31'd0, uif.o_Tx_Done},   32'd1);
    chk("tx_AB_active_871", {31'd0, uif.o_Tx_Active}, 32'd0);
    chk("tx_AB_serial_871", {31'd0, uif.o_Tx_Serial}, 32'd1);
    @(negedge clk);
    chk("tx_AB_done_872", {31'd0, uif.o_Tx_Done}, 32'd0);
    chk("tx_AB_done_once", tx_done_cnt - done_base, 1);

    // RX 0x3F with stretched start and short data/stop bits
    repeat (20) @(negedge clk);
    dv_base = rx_dv_cnt;
    sb.push_back(8'h3F);
    send_rx(8'h3F, 96, 86, 1'b1);
    repeat (100) @(negedge clk);
    chk("rx_3F_dv_count", rx_dv_cnt - dv_base, 1);
    chk("rx_3F_byte", {24'd0, uif.o_Rx_Byte}, 32'h3F);

    // Glitch: 20 low cycles never reach mid-bit
    dv_base = rx_dv_cnt;
    rx_line = 1'b0;
    repeat (20) @(negedge clk);
    rx_line = 1'b1;
    repeat (150) @(negedge clk);
    chk("rx_glitch_no_dv", rx_dv_cnt - dv_base, 0);
    chk("rx_glitch_byte_kept", {24'd0, uif.o_Rx_Byte}, 32'h3F);

    // Framing error followed by a good frame
    send_rx(8'h5A, c_CPB, c_CPB, 1'b0);
    repeat (150) @(negedge clk);
    chk("rx_frame_err_no_dv", rx_dv_cnt - dv_base, 0);
    chk("rx_frame_err_byte_kept", {24'd0, uif.o_Rx_Byte}, 32'h3F);
    sb.push_back(8'hC3);
    send_rx(8'hC3, c_CPB, c_CPB, 1'b1);
    repeat (100) @(negedge clk);
    chk("rx_C3_dv_count", rx_dv_cnt - dv_base, 1);
    chk("rx_C3_byte", {24'd0, uif.o_Rx_Byte}, 32'hC3);

    // Loopback, back-to-back, with a mid-frame strobe that must be ignored
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    dv_base   = rx_dv_cnt;
    done_base = tx_done_cnt;
    sb.push_back(8'h00);
    tx_start(8'h00);
    repeat (300) @(negedge clk);
    uif.i_Tx_DV   = 1'b1;
    uif.i_Tx_Byte = 8'hEE;
    @(negedge clk);
    uif.i_Tx_DV   = 1'b0;
    wait_tx_done("lb_00_done");
    sb.push_back(8'hFF);
    tx_start(8'hFF);
    wait_tx_done("lb_FF_done");
    sb.push_back(8'h55);
    tx_start(8'h55);
    wait_tx_done("lb_55_done");
    repeat (200) @(negedge clk);
    chk("lb_tx_done_count", tx_done_cnt - done_base, 3);
    chk("lb_rx_dv_count", rx_dv_cnt - dv_base, 3);
    chk("lb_last_byte", {24'd0, uif.o_Rx_Byte}, 32'h55);

    // Reset in the middle of DATA on both directions
    loop_en = 1'b0;
    rx_line = 1'b1;
    repeat (10) @(negedge clk);
    frame = {1'b1, 8'h99, 1'b0};
    uif.i_Tx_DV   = 1'b1;
    uif.i_Tx_Byte = 8'h5A;
    for (int c = 0; c < 400; c++) begin
      rx_line = frame[c / c_CPB];
      @(negedge clk);
      uif.i_Tx_DV = 1'b0;
    end
    chk("mid_tx_active", {31'd0, uif.o_Tx_Active}, 32'd1);
    rst     = 1'b1;
    rx_line = 1'b1;
    @(negedge clk);
    chk("mrst_tx_serial", {31'd0, uif.o_Tx_Serial}, 32'd1);
    chk("mrst_tx_active", {31'd0, uif.o_Tx_Active}, 32'd0);
    chk("mrst_tx_done",   {31'd0, uif.o_Tx_Done},   32'd0);
    chk("mrst_rx_dv",     {31'd0, uif.o_Rx_DV},     32'd0);
    chk("mrst_rx_byte",   {24'd0, uif.o_Rx_Byte},   32'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    loop_en = 1'b1;
    dv_base = rx_dv_cnt;
    sb.push_back(8'h81);
    tx_start(8'h81);
    wait_tx_done("post_rst_81_done");
    repeat (200) @(negedge clk);
    chk("post_rst_81_dv", rx_dv_cnt - dv_base, 1);
    chk("post_rst_81_byte", {24'd0, uif.o_Rx_Byte}, 32'h81);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_txrx.md
# uart_txrx

Full-duplex 8N1 UART serial port: one transmitter and one receiver sharing a single clock and a compile-time baud divider. Parallel-side handshakes use one-cycle strobes. The block sits between a byte-oriented host and the external serial pins. Default timing targets 115200 baud from a 10 MHz clock.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per serial bit (clock frequency / baud rate). Legal values are integers of 4 or more.
- i_Clock  input  1  sole clock; all logic is on the rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Tx_DV  input  1  one-cycle strobe: transmit i_Tx_Byte.
- i_Tx_Byte  input  8  byte to transmit; sampled only in the cycle i_Tx_DV is accepted.
- o_Tx_Active  output  1  high while a transmit frame is on the line.
- o_Tx_Serial  output  1  serial TX line; idles high.
- o_Tx_Done  output  1  one-cycle pulse after the stop bit completes.
- i_Rx_Serial  input  1  asynchronous serial RX line; idles high.
- o_Rx_DV  output  1  one-cycle pulse when a valid byte is received.
- o_Rx_Byte  output  8  last validly received byte.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX state machine has five states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: o_Tx_Serial=1, o_Tx_Active=0. When i_Tx_DV=1, latch i_Tx_Byte and go to START.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: drive bit index 0..7 for CLKS_PER_BIT cycles each.
  - STOP: drive 1 for CLKS_PER_BIT cycles.
  - CLEANUP: one cycle with o_Tx_Done=1 and o_Tx_Active=0, then return to IDLE.
  - i_Tx_DV is ignored in every state except IDLE. No queueing.
- RX front end: i_Rx_Serial passes through a 2-flop synchronizer. Both flops reset to 1. All RX decisions use the synchronized signal.
- RX state machine has five states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: wait for the synchronized line to be 0.
  - START: count (CLKS_PER_BIT-1)/2 cycles to reach mid-bit. If the line is still 0, clear the counter and go to DATA. Otherwise it was a glitch: return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into an internal shift register, LSB first. After 8 samples, go to STOP.
  - STOP: sample after CLKS_PER_BIT more cycles.
    - Sample = 1: load o_Rx_Byte from the shift register and pulse o_Rx_DV for 1 cycle (in CLEANUP).
    - Sample = 0 (framing error): no o_Rx_DV, o_Rx_Byte unchanged.
  - CLEANUP: one cycle, then IDLE.
- o_Rx_Byte holds its value until the next valid frame completes.
- TX and RX are fully independent and may run simultaneously.
- Counters are sized to hold CLKS_PER_BIT-1. Bit index is 3 bits.

## Timing
- Reset values:
  - o_Tx_Serial=1; o_Tx_Active=0; o_Tx_Done=0; o_Rx_DV=0; o_Rx_Byte=8'h00.
  - Both state machines go to IDLE.
  - Reset mid-frame aborts immediately. TX line is high the cycle after reset is sampled.
- TX timing:
  - i_Tx_DV is accepted at edge T. The cycle after T has o_Tx_Serial=0 and o_Tx_Active=1.
  - The serial frame lasts exactly 10×CLKS_PER_BIT cycles.
  - o_Tx_Done is high in the single cycle following the last stop-bit cycle.
  - The next i_Tx_DV is accepted no earlier than the cycle after the o_Tx_Done pulse.
- RX timing:
  - Sample points fall at (CLKS_PER_BIT-1)/2 + k×CLKS_PER_BIT cycles after the detected falling edge (k=1..8 for data, k=9 for stop), plus 2 cycles of synchronizer latency.
  - o_Rx_DV and the o_Rx_Byte update take effect 1 cycle after the stop sample.
  - Tolerance: RX decodes correctly whenever each sample point lies inside its bit. This includes a stretched start bit combined with data bits a few cycles short.
- RX is back in IDLE, able to detect a new start bit, 2 cycles after the stop sample.

## Test plan
- TX 0xAB, CLKS_PER_BIT=87:
  - o_Tx_Serial shows 0,1,1,0,1,0,1,0,1,1, each held 87 cycles.
  - o_Tx_Active is high for 870 cycles.
  - o_Tx_Done pulses once in cycle 871 after acceptance.
- RX 0x3F with a 96-cycle start bit and 86-cycle data and stop bits -> o_Rx_DV pulses once and o_Rx_Byte=0x3F.
- RX glitch: line low for 20 cycles, then high -> no o_Rx_DV; o_Rx_Byte keeps its prior value.
- RX framing error: send 0x5A with the stop bit held low -> no o_Rx_DV, o_Rx_Byte unchanged. A following valid 0xC3 frame is received correctly.
- Loopback (o_Tx_Serial to i_Rx_Serial), back-to-back bytes 0x00, 0xFF, 0x55 -> each appears on o_Rx_Byte with one o_Rx_DV pulse.
  - In the same run, an i_Tx_DV pulse issued mid-frame is ignored: exactly 3 o_Tx_Done pulses.
- Reset asserted during DATA on both TX and RX:
  - The cycle after reset, all outputs are at reset values.
  - A new 0x81 transfer afterwards succeeds.
